bsg_arb_rr_scan: RTL
====================

Name: bsg_arb_rr_scan

Overview:
- Registered round-robin arbiter for N requesters with a valid/yumi handshake to a single consumer.
- Sits directly upstream of the prefix-OR scan stage: it drives request vectors into the scan to produce "at-or-above" thermometer masks.
- From the scan output it derives one-hot lowest-set-bit grants.
- Holds the grant stable until the consumer accepts it.

Parameters:
- ELS_P, 7, number of requesters (2..32)
- TAG_W_P, 3, width of the encoded grant index, equal to ceil(log2(ELS_P))

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- reset_n_i  input  1  asynchronous active-low reset
- reqs_i  input  ELS_P  request vector; bit k = requester k wants service
- v_o  output  1  a grant is currently presented
- grants_o  output  ELS_P  one-hot grant; all-zero when v_o=0
- tag_o  output  TAG_W_P  binary index of the granted requester; 0 when v_o=0
- yumi_i  input  1  consumer accepts the presented grant this cycle; only legal when v_o=1

Behaviour:
- Reset: asynchronous, active-low. While reset_n_i=0:
  - state=IDLE, v_o=0, grants_o=0, tag_o=0
  - last_r=ELS_P-1, so requester 0 has top priority after reset
  - Reset asserted mid-grant drops the grant immediately; no handshake completes.
- Selection function sel(reqs, last):
  - mask = reqs & ~thermo(last), where thermo(last) has bits [0..last] set. Mask therefore keeps requesters strictly above last.
  - pick = mask if mask≠0, else reqs.
  - scan = prefix-OR of pick from bit 0 upward.
  - onehot = scan & ~(scan<<1), i.e. the lowest set bit of pick.
  - If pick=0, onehot=0.
- State IDLE:
  - If reqs_i≠0: register grant_r=sel(reqs_i,last_r), go GRANT. v_o rises on the next cycle (1-cycle request-to-grant latency).
  - If reqs_i=0: stay IDLE.
- State GRANT:
  - v_o=1; grants_o=grant_r; tag_o=encode(grant_r).
  - Outputs hold stable every cycle yumi_i=0, even if reqs_i changes or the granted requester deasserts. The grant is sticky; requesters must not withdraw.
  - On yumi_i=1: last_r←encode(grant_r).
  - Next grant in the same cycle = sel(reqs_i & ~grant_r, encode(grant_r)).
    - If nonzero: load it into grant_r and stay GRANT. Back-to-back grants, v_o stays 1, no bubble.
    - Else: grant_r←0, go IDLE, v_o=0 next cycle.
  - In the post-yumi arbitration, the just-served requester's bit is excluded for that cycle only. Its new request is considered from the following cycle.
- yumi_i while v_o=0 is ignored; there is no state change.
- Fairness: with all ELS_P bits continuously requested and yumi_i=1 every cycle, grants rotate 0,1,...,ELS_P-1,0,...
- Wrap-around: when last_r=ELS_P-1, mask is all-zero and the pick falls back to the lowest set request.

Optional Feature:
- Macro: BSG_ARB_RR_LOCK_EN.
- Defined:
  - Adds input port lock_i (1 bit).
  - On yumi_i=1 with lock_i=1, last_r is NOT updated.
  - If reqs_i bit of the current grant is still 1, grant_r is kept and state stays GRANT (same requester re-granted back-to-back).
  - Otherwise arbitration proceeds as the normal yumi case, but with the old last_r.
  - lock_i is ignored when yumi_i=0.
- Undefined: no lock_i port; behaviour identical to lock_i tied to 0.

Test Plan:
- Reset then reqs_i=7'b0000000 for 5 cycles → v_o=0, grants_o=0, tag_o=0 throughout; async assert of reset_n_i mid-GRANT → v_o=0 in the same cycle.
- After reset reqs_i=7'b1111111, yumi_i=1 every cycle → v_o=1 from cycle 2; tag_o sequence 0,1,2,3,4,5,6,0 with no bubbles.
- reqs_i=7'b1010010, yumi_i=0 for 4 cycles → grants_o=7'b0000010 held stable for all 4 cycles. Change reqs_i to 7'b1000000 during the hold → grant unchanged.
- last_r=6 (after serving requester 6), reqs_i=7'b0100100 → next grant tag_o=2 (wrap-around fallback). Then yumi → tag_o=5.
- Single requester reqs_i=7'b0001000, yumi_i=1 on first valid cycle → v_o goes 1 for one cycle, 0 the next cycle (served bit excluded), then 1 again the following cycle with tag_o=3.
- BSG_ARB_RR_LOCK_EN: reqs_i=7'b0000011, grant tag_o=0, yumi_i=1 with lock_i=1 for 3 cycles → tag_o stays 0; drop lock_i → next grant tag_o=1.

Source files
------------

// File: rtl/bsg_arb_rr_scan.sv
`default_nettype none
// ============================================================================
// bsg_arb_rr_scan : registered round-robin arbiter, valid/yumi to one consumer.
// Optional lock input enabled by defining BSG_ARB_RR_LOCK_EN.
// Revision: 1.0
// ============================================================================
module bsg_arb_rr_scan #(
    parameter int ELS_P   = 7,
    parameter int TAG_W_P = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [ELS_P-1:0]   reqs_i,
    output logic               v_o,
    output logic [ELS_P-1:0]   grants_o,
    output logic [TAG_W_P-1:0] tag_o,
`ifdef BSG_ARB_RR_LOCK_EN
    input  logic               lock_i,
`endif
    input  logic               yumi_i
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [ELS_P-1:0]     grant_q, grant_d;
    logic [TAG_W_P-1:0]   last_q, last_d;
    logic [ELS_P-1:0]     w_next;
    logic [TAG_W_P-1:0]   w_cur_tag;
    logic                 w_lock;

    // Lowest-set-bit pick among requesters strictly above last, else wrap to lowest overall.
    function automatic logic [ELS_P-1:0] sel(input logic [ELS_P-1:0]   reqs,
                                             input logic [TAG_W_P-1:0] last);
        logic [ELS_P-1:0] thermo;
        logic [ELS_P-1:0] mask;
        logic [ELS_P-1:0] pick;
        logic [ELS_P-1:0] scan;
        for (int i = 0; i < ELS_P; i++) begin
            thermo[i] = (i <= int'(last));
        end
        mask    = reqs & ~thermo;
        pick    = (|mask) ? mask : reqs;
        scan[0] = pick[0];
        for (int i = 1; i < ELS_P; i++) begin
            scan[i] = scan[i-1] | pick[i];
        end
        return scan & ~(scan << 1);
    endfunction

    function automatic logic [TAG_W_P-1:0] encode(input logic [ELS_P-1:0] oh);
        logic [TAG_W_P-1:0] tag;
        tag = '0;
        for (int i = 0; i < ELS_P; i++) begin
            if (oh[i]) begin
                tag = tag | TAG_W_P'(i);
            end
        end
        return tag;
    endfunction

`ifdef BSG_ARB_RR_LOCK_EN
    assign w_lock = lock_i;
`else
    assign w_lock = 1'b0;
`endif

    assign w_cur_tag = encode(grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        w_next  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|reqs_i) begin
                    grant_d = sel(reqs_i, last_q);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A locked accept re-grants the same requester while it still asks.
                if (yumi_i && !(w_lock && |(reqs_i & grant_q))) begin
                    w_next = sel(reqs_i & ~grant_q, w_lock ? last_q : w_cur_tag);
                    if (!w_lock) begin
                        last_d = w_cur_tag;
                    end
                    if (|w_next) begin
                        grant_d = w_next;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= TAG_W_P'(ELS_P - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign v_o      = (state_q == ST_GRANT);
    assign grants_o = grant_q;
    assign tag_o    = w_cur_tag;

endmodule
`default_nettype wire
